pc_ras: RTL and testbench

Parametrised program-counter generator for the fetch stage, successor to the basic PC register. It adds selectable XLEN, compressed-instruction stepping, a prioritised trap/jump/predict redirect path, and an internal return-address stack (RAS) that predicts function returns. One PC is produced per cycle; fetch and decode feed back hints about the instruction currently at `pc`.

---
 rtl/pc_ras.sv | 103 ++++++++++
 tb/tb_pc_ras.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// Fetch-stage program counter with prioritised redirects and an internal
// return-address stack used to predict function returns.
module pc_ras #(
   parameter int               XLEN       = 32,
   parameter logic [XLEN-1:0]  START_ADDR = '0,
   parameter int               RAS_DEPTH  = 4,
   parameter bit               C_EXT      = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_addr,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_addr,
   input  logic            is_call,
   input  logic            is_ret,
   input  logic            is_c,
   output logic [XLEN-1:0] pc,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]   DEPTH_CNT  = CW'(RAS_DEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   top;
   logic [CW-1:0]   count;

   logic [XLEN-1:0] step;
   logic [XLEN-1:0] link;
   logic [XLEN-1:0] ras_top;
   logic [XLEN-1:0] next_pc;
   logic            update;
   logic            push;
   logic            pop;
   logic            replace;

   assign ras_empty = (count == '0);
   assign ras_full  = (count == DEPTH_CNT);
   assign ras_top   = ras_mem[top];

   always_comb begin
      step    = (C_EXT && is_c) ? XLEN'(2) : XLEN'(4);
      link    = pc + step;
      update  = !trap && !jump && !stall;
      // A call+return on an empty stack degenerates into a plain push.
      push    = update && is_call && (!is_ret || ras_empty);
      pop     = update && is_ret && !is_call && !ras_empty;
      replace = update && is_call && is_ret && !ras_empty;

      next_pc = pc;
      if (trap)
         next_pc = trap_addr & ALIGN_MASK;
      else if (jump)
         next_pc = jump_addr & ALIGN_MASK;
      else if (stall)
         next_pc = pc;
      else if (is_ret && !ras_empty)
         next_pc = ras_top & ALIGN_MASK;
      else if (pred_taken)
         next_pc = pred_addr & ALIGN_MASK;
      else
         next_pc = link & ALIGN_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= START_ADDR;
         top   <= '0;
         count <= '0;
      end else begin
         pc <= next_pc;
         if (trap) begin
            top   <= '0;
            count <= '0;
         end else if (push) begin
            // When full the pointer wraps onto the oldest entry; count saturates.
            top <= top + PW'(1);
            if (count != DEPTH_CNT)
               count <= count + CW'(1);
         end else if (pop) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (push)
            ras_mem[top + PW'(1)] <= link;
         else if (replace)
            ras_mem[top] <= link;
      end
   end

endmodule

// File: tb/tb_pc_ras.sv
// Directed scoreboard bench for pc_ras: stimulus pushes expected outputs,
// a monitor pops and compares them one cycle later.
module tb_pc_ras;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, trap = 1'b0, jump = 1'b0, pred_taken = 1'b0;
   logic        is_call = 1'b0, is_ret = 1'b0, is_c = 1'b0;
   logic [31:0] trap_addr = '0, jump_addr = '0, pred_addr = '0;
   logic [31:0] pc;
   logic        ras_empty, ras_full;

   // second instance without compressed support, normally held by stall
   logic        stall2 = 1'b1, jump2 = 1'b0, is_c2 = 1'b1, zero = 1'b0;
   logic [31:0] jump_addr2 = '0, zero32 = '0;
   logic [31:0] pc2;
   logic        ras_empty2, ras_full2;
   logic [31:0] exp2 = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        e;
      logic        f;
      logic [31:0] pc2;
   } exp_t;
   exp_t sbq[$];

   pc_ras #(.XLEN(32), .START_ADDR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_addr(trap_addr),
      .jump(jump), .jump_addr(jump_addr), .pred_taken(pred_taken),
      .pred_addr(pred_addr), .is_call(is_call), .is_ret(is_ret), .is_c(is_c),
      .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full));

   pc_ras #(.XLEN(32), .START_ADDR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b0)) dut2 (
      .clk(clk), .rst(rst), .stall(stall2), .trap(zero), .trap_addr(zero32),
      .jump(jump2), .jump_addr(jump_addr2), .pred_taken(zero),
      .pred_addr(zero32), .is_call(zero), .is_ret(zero), .is_c(is_c2),
      .pc(pc2), .ras_empty(ras_empty2), .ras_full(ras_full2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec%0d actual=%h required=%h", name, id, act, req);
      end
   endtask

   // Drives one cycle of hints starting at a falling edge.
   task automatic step(input int id, input logic tr, input logic [31:0] ta,
                       input logic jp, input logic [31:0] ja, input logic st,
                       input logic pt, input logic [31:0] pa, input logic cl,
                       input logic rt, input logic c, input logic [31:0] epc,
                       input logic ee, input logic ef);
      exp_t x;
      trap = tr; trap_addr = ta; jump = jp; jump_addr = ja; stall = st;
      pred_taken = pt; pred_addr = pa; is_call = cl; is_ret = rt; is_c = c;
      x.id = id; x.pc = epc; x.e = ee; x.f = ef; x.pc2 = exp2;
      sbq.push_back(x);
      $display("vec%0d issued expect pc=%h empty=%0b full=%0b pc2=%h", id, epc, ee, ef, exp2);
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("pc", x.id, pc, x.pc);
            chk("ras_empty", x.id, 32'(ras_empty), 32'(x.e));
            chk("ras_full", x.id, 32'(ras_full), 32'(x.f));
            chk("pc_c0", x.id, pc2, x.pc2);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      #2;
      chk("reset_pc", 0, pc, 32'h0);
      chk("reset_empty", 0, 32'(ras_empty), 32'd1);
      chk("reset_full", 0, 32'(ras_full), 32'd0);
      chk("reset_empty_c0", 0, 32'(ras_empty2), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      //   id tr ta      jp ja         st pt pa          cl rt c  pc         e  f
      step(1, 0, 0,      0, 0,         0, 0, 0,          0, 0, 0, 32'h4,     1, 0);
      step(2, 0, 0,      0, 0,         0, 0, 0,          0, 0, 0, 32'h8,     1, 0);
      step(3, 0, 0,      0, 0,         0, 0, 0,          0, 0, 0, 32'hC,     1, 0);
      step(4, 0, 0,      0, 0,         0, 0, 0,          0, 0, 1, 32'hE,     1, 0);
      step(5, 0, 0,      0, 0,         0, 0, 0,          0, 0, 1, 32'h10,    1, 0);
      step(6, 0, 0,      1, 32'h100,   0, 0, 0,          0, 0, 0, 32'h100,   1, 0);
      step(7, 0, 0,      0, 0,         0, 1, 32'h400,    1, 0, 0, 32'h400,   0, 0);
      step(8, 0, 0,      0, 0,         0, 0, 0,          0, 1, 0, 32'h104,   1, 0);
      step(9, 0, 0,      0, 0,         0, 0, 0,          0, 0, 0, 32'h108,   1, 0);
      step(10, 0, 0,     0, 0,         0, 1, 32'h2000,   1, 0, 0, 32'h2000,  0, 0);
      step(11, 0, 0,     0, 0,         0, 1, 32'h3000,   1, 0, 0, 32'h3000,  0, 0);
      step(12, 0, 0,     0, 0,         0, 1, 32'h4000,   1, 0, 0, 32'h4000,  0, 0);
      step(13, 0, 0,     0, 0,         0, 1, 32'h5000,   1, 0, 0, 32'h5000,  0, 1);
      step(14, 0, 0,     0, 0,         0, 1, 32'h6000,   1, 0, 0, 32'h6000,  0, 1);
      step(15, 0, 0,     0, 0,         0, 0, 0,          0, 1, 0, 32'h5004,  0, 0);
      step(16, 0, 0,     0, 0,         0, 0, 0,          0, 1, 0, 32'h4004,  0, 0);
      step(17, 0, 0,     0, 0,         0, 0, 0,          0, 1, 0, 32'h3004,  0, 0);
      step(18, 0, 0,     0, 0,         0, 0, 0,          0, 1, 0, 32'h2004,  1, 0);
      step(19, 0, 0,     0, 0,         0, 0, 0,          0, 1, 0, 32'h2008,  1, 0);
      step(20, 0, 0,     0, 0,         0, 1, 32'h7000,   1, 0, 0, 32'h7000,  0, 0);
      step(21, 0, 0,     0, 0,         0, 1, 32'h7100,   1, 0, 0, 32'h7100,  0, 0);
      step(22, 1, 32'h800, 1, 32'h200, 1, 0, 0,          1, 0, 0, 32'h800,   1, 0);
      step(23, 0, 0,     1, 32'h300,   1, 0, 0,          0, 0, 0, 32'h300,   1, 0);
      step(24, 0, 0,     0, 0,         0, 0, 32'h900,    1, 0, 0, 32'h304,   0, 0);
      step(25, 0, 0,     0, 0,         0, 1, 32'hA00,    0, 1, 0, 32'h304,   1, 0);
      step(26, 0, 0,     0, 0,         0, 1, 32'hB00,    1, 1, 0, 32'hB00,   0, 0);
      step(27, 0, 0,     0, 0,         0, 0, 0,          1, 1, 1, 32'h308,   0, 0);
      step(28, 0, 0,     0, 0,         0, 0, 0,          0, 1, 0, 32'hB02,   1, 0);
      step(29, 0, 0,     0, 0,         1, 0, 0,          1, 0, 0, 32'hB02,   1, 0);
      step(30, 0, 0,     0, 0,         1, 0, 0,          1, 0, 0, 32'hB02,   1, 0);
      step(31, 0, 0,     0, 0,         1, 0, 0,          1, 0, 0, 32'hB02,   1, 0);
      step(32, 0, 0,     0, 0,         0, 0, 0,          0, 0, 0, 32'hB06,   1, 0);
      step(33, 0, 0,     0, 0,         0, 1, 32'h1235,   0, 0, 0, 32'h1234,  1, 0);
      jump2 = 1'b1; jump_addr2 = 32'h203; exp2 = 32'h200;
      step(34, 0, 0,     1, 32'h203,   0, 0, 0,          0, 0, 0, 32'h202,   1, 0);
      jump2 = 1'b0; stall2 = 1'b0; exp2 = 32'h204;
      step(35, 0, 0,     0, 0,         0, 1, 32'h50,     1, 0, 0, 32'h50,    0, 0);
      stall2 = 1'b1;
      step(36, 0, 0,     0, 0,         0, 1, 32'h60,     1, 0, 0, 32'h60,    0, 0);
      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      chk("async_pc", 37, pc, 32'h0);
      chk("async_empty", 37, 32'(ras_empty), 32'd1);
      chk("async_full", 37, 32'(ras_full), 32'd0);
      chk("async_pc_c0", 37, pc2, 32'h0);
      @(negedge clk);
      chk("hold_pc", 38, pc, 32'h0);
      chk("hold_empty", 38, 32'(ras_empty), 32'd1);
      rst = 1'b0;
      exp2 = 32'h0;
      step(39, 0, 0,     0, 0,         0, 0, 0,          0, 0, 0, 32'h4,     1, 0);
      step(40, 0, 0,     0, 0,         0, 0, 0,          0, 0, 0, 32'h8,     1, 0);
      for (int i = 0; i < 10 && sbq.size() > 0; i++)
         @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
